// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: control handshake, memory port, and the decoded
// instruction fields. The fetch register drives the slave side.
interface instr_fetch_if #(
  parameter int WIDTH = 32
);
  logic               IRWrite;
  logic               Flush;
  logic [WIDTH-1:0]   PC;
  logic               MemReady;
  logic [WIDTH-1:0]   MemData;
  logic               MemRead;
  logic [WIDTH-1:0]   MemAddr;
  logic               Busy;
  logic               IRDone;
  logic               Fault;
  logic [WIDTH-1:0]   Instr;
  logic [5:0]         Opcode;
  logic [4:0]         Rs;
  logic [4:0]         Rt;
  logic [4:0]         Rd;
  logic [4:0]         Shamt;
  logic [5:0]         Funct;
  logic [WIDTH/2-1:0] Imm;
  logic [25:0]        JAddr;
  logic [WIDTH-1:0]   MDR;

  modport master (
    output IRWrite, Flush, PC, MemReady, MemData,
    input  MemRead, MemAddr, Busy, IRDone, Fault, Instr,
           Opcode, Rs, Rt, Rd, Shamt, Funct, Imm, JAddr, MDR
  );

  modport slave (
    input  IRWrite, Flush, PC, MemReady, MemData,
    output MemRead, MemAddr, Busy, IRDone, Fault, Instr,
           Opcode, Rs, Rt, Rd, Shamt, Funct, Imm, JAddr, MDR
  );
endinterface

// File: rtl/instr_fetch_reg.sv
// Instruction fetch register: latches the fetch address, waits for memory
// with a bounded timeout, holds the instruction and exposes its fields.
//
// state | meaning
// IDLE  | waiting for IRWrite; Fault is held here until the next accepted fetch
// FETCH | MemRead asserted, waiting for MemReady, Flush or timeout
// DONE  | new instruction held, IRDone pulses for this one cycle
module instr_fetch_reg #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] mdr_q;
  logic             fault_q, fault_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      mdr_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      if (bus.MemReady) begin
        mdr_q <= bus.MemData;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    fault_d = fault_q;
    unique case (state_q)
      IDLE: begin
        if (bus.IRWrite) begin
          addr_d  = bus.PC;
          fault_d = 1'b0;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // Flush outranks a simultaneous MemReady, which outranks timeout.
        if (bus.Flush) begin
          state_d = IDLE;
        end else if (bus.MemReady) begin
          instr_d = bus.MemData;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(TIMEOUT)) begin
            fault_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.MemRead = (state_q == FETCH);
  assign bus.Busy    = (state_q != IDLE);
  assign bus.IRDone  = (state_q == DONE);
  assign bus.Fault   = fault_q;
  assign bus.MemAddr = addr_q;
  assign bus.Instr   = instr_q;
  assign bus.MDR     = mdr_q;

  assign bus.Opcode = instr_q[31:26];
  assign bus.Rs     = instr_q[25:21];
  assign bus.Rt     = instr_q[20:16];
  assign bus.Rd     = instr_q[15:11];
  assign bus.Shamt  = instr_q[10:6];
  assign bus.Funct  = instr_q[5:0];
  assign bus.Imm    = instr_q[WIDTH/2-1:0];
  assign bus.JAddr  = instr_q[25:0];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Bench for instr_fetch_reg: directed scenarios plus randomized fetch
// transactions checked against a transaction-level expectation model.
module tb_instr_fetch_reg;

  localparam int TIMEOUT = 15;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  logic [31:0] exp_instr;
  logic [31:0] exp_mdr;
  logic        exp_fault;

  instr_fetch_if #(.WIDTH(32)) bus ();

  instr_fetch_reg #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_fields();
    check("instr",  bus.Instr,  exp_instr);
    check("opcode", bus.Opcode, (exp_instr >> 26) & 32'h3f);
    check("rs",     bus.Rs,     (exp_instr >> 21) & 32'h1f);
    check("rt",     bus.Rt,     (exp_instr >> 16) & 32'h1f);
    check("rd",     bus.Rd,     (exp_instr >> 11) & 32'h1f);
    check("shamt",  bus.Shamt,  (exp_instr >> 6)  & 32'h1f);
    check("funct",  bus.Funct,  exp_instr & 32'h3f);
    check("imm",    bus.Imm,    exp_instr % 32'h10000);
    check("jaddr",  bus.JAddr,  exp_instr % 32'h4000000);
  endtask

  // Called at a negedge with the DUT in IDLE. k / fl: FETCH cycle (1-based)
  // carrying MemReady / Flush, 0 for never.
  task automatic run_fetch(input logic [31:0] pc, input int k, input logic [31:0] data,
                           input int fl);
    int  c;
    int  outcome;
    bus.IRWrite  = 1'b1;
    bus.PC       = pc;
    bus.Flush    = 1'($urandom_range(0, 1));
    bus.MemReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp_fault = 1'b0;
    outcome   = 0;
    c         = 1;
    while (outcome == 0) begin
      check("fetch_memread", bus.MemRead, 1);
      check("fetch_busy",    bus.Busy,    1);
      check("fetch_addr",    bus.MemAddr, pc);
      check("fetch_irdone",  bus.IRDone,  0);
      check("fetch_fault",   bus.Fault,   0);
      bus.IRWrite  = 1'($urandom_range(0, 1));
      bus.PC       = $urandom;
      bus.Flush    = (c == fl);
      bus.MemReady = (c == k);
      bus.MemData  = (c == k) ? data : $urandom;
      @(posedge clk);
      @(negedge clk);
      if (c == k) exp_mdr = data;
      if (c == fl) outcome = 1;
      else if (c == k) begin outcome = 2; exp_instr = data; end
      else if (c == TIMEOUT) begin outcome = 3; exp_fault = 1'b1; end
      c++;
    end
    bus.Flush    = 1'b0;
    bus.MemReady = 1'b0;
    if (outcome == 2) begin
      check("done_irdone",  bus.IRDone,  1);
      check("done_busy",    bus.Busy,    1);
      check("done_memread", bus.MemRead, 0);
      check("done_fault",   bus.Fault,   0);
      check("done_mdr",     bus.MDR,     exp_mdr);
      check_fields();
      // IRWrite / Flush here must be ignored; IRWrite may stay high into IDLE.
      bus.IRWrite = 1'($urandom_range(0, 1));
      bus.Flush   = 1'($urandom_range(0, 1));
      bus.PC      = $urandom;
      @(posedge clk);
      @(negedge clk);
      bus.Flush = 1'b0;
      check("after_irdone", bus.IRDone, 0);
      check("after_busy",   bus.Busy,   0);
      check("after_instr",  bus.Instr,  exp_instr);
    end else begin
      check("end_irdone",  bus.IRDone,  0);
      check("end_busy",    bus.Busy,    0);
      check("end_memread", bus.MemRead, 0);
      check("end_fault",   bus.Fault,   exp_fault);
      check("end_instr",   bus.Instr,   exp_instr);
      check("end_mdr",     bus.MDR,     exp_mdr);
      bus.IRWrite = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.IRWrite  = 1'b0;
      bus.Flush    = 1'($urandom_range(0, 1));
      bus.MemReady = 1'($urandom_range(0, 1));
      bus.MemData  = $urandom;
      @(posedge clk);
      @(negedge clk);
      if (bus.MemReady) exp_mdr = bus.MemData;
      check("idle_busy",  bus.Busy,  0);
      check("idle_fault", bus.Fault, exp_fault);
      check("idle_instr", bus.Instr, exp_instr);
      check("idle_mdr",   bus.MDR,   exp_mdr);
    end
    bus.Flush    = 1'b0;
    bus.MemReady = 1'b0;
  endtask

  initial begin
    int k;
    int fl;
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    bus.IRWrite = 1'b0;
    bus.Flush = 1'b0;
    bus.PC = '0;
    bus.MemReady = 1'b0;
    bus.MemData = '0;
    exp_instr = '0;
    exp_mdr = '0;
    exp_fault = 1'b0;
    #12;
    check("rst_busy",    bus.Busy,    0);
    check("rst_memread", bus.MemRead, 0);
    check("rst_irdone",  bus.IRDone,  0);
    check("rst_fault",   bus.Fault,   0);
    check("rst_instr",   bus.Instr,   0);
    check("rst_mdr",     bus.MDR,     0);
    check("rst_addr",    bus.MemAddr, 0);
    @(negedge clk);
    reset = 1'b1;

    run_fetch(32'h0040_0000, 2, 32'h2008_FFFC, 0);
    check("d1_addr",   bus.MemAddr, 32'h0040_0000);
    check("d1_opcode", bus.Opcode,  6'h08);
    check("d1_rt",     bus.Rt,      5'd8);
    check("d1_imm",    bus.Imm,     16'hFFFC);
    idle_cycles(1);

    run_fetch(32'h0040_0004, 0, 32'h0, 0);
    check("d2_fault", bus.Fault, 1);
    idle_cycles(2);

    run_fetch(32'h0040_0008, 1, 32'h1234_5678, 1);
    check("d3_mdr",   bus.MDR,   32'h1234_5678);
    check("d3_instr", bus.Instr, 32'h2008_FFFC);
    idle_cycles(1);

    run_fetch(32'h0040_000C, 3, 32'h0C10_0010, 0);
    check("d4_opcode", bus.Opcode, 6'h03);
    check("d4_jaddr",  bus.JAddr,  26'h010_0010);
    check("d4_funct",  bus.Funct,  6'h10);
    check("d4_shamt",  bus.Shamt,  5'd0);

    for (int t = 0; t < 60; t++) begin
      k  = $urandom_range(1, 20);
      fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 0;
      run_fetch($urandom, k, $urandom, fl);
      idle_cycles($urandom_range(0, 2));
    end

    // Asynchronous reset between edges while fetching.
    bus.IRWrite = 1'b1;
    bus.PC = 32'hDEAD_BEE0;
    @(posedge clk);
    @(negedge clk);
    bus.IRWrite = 1'b0;
    check("ar_pre_memread", bus.MemRead, 1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_memread", bus.MemRead, 0);
    check("ar_busy",    bus.Busy,    0);
    check("ar_irdone",  bus.IRDone,  0);
    check("ar_fault",   bus.Fault,   0);
    check("ar_instr",   bus.Instr,   0);
    check("ar_mdr",     bus.MDR,     0);
    check("ar_addr",    bus.MemAddr, 0);
    exp_instr = '0;
    exp_mdr   = '0;
    exp_fault = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_fetch(32'h0000_1000, 4, 32'hA5A5_1234, 0);
    idle_cycles(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_reg.md
INSTR_FETCH_REG -- requirements
Module: instr_fetch_reg

Interface
REQ-001 Parameter: WIDTH, default 32, instruction/data word width; Imm output is WIDTH/2 bits, the sign-extension stage's input width.
REQ-002 Parameter: TIMEOUT, default 15, maximum FETCH cycles spent waiting for MemReady.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: IRWrite  input  1  fetch start request from control unit.
REQ-006 Port: Flush  input  1  abort any in-progress fetch.
REQ-007 Port: PC  input  WIDTH  fetch address.
REQ-008 Port: MemReady  input  1  memory returns valid MemData this cycle.
REQ-009 Port: MemData  input  WIDTH  memory read data.
REQ-010 Port: MemRead  output  1  memory read request.
REQ-011 Port: MemAddr  output  WIDTH  address latched at fetch start.
REQ-012 Port: Busy  output  1  FSM not in IDLE.
REQ-013 Port: IRDone  output  1  one-cycle pulse when a new instruction is held.
REQ-014 Port: Fault  output  1  sticky timeout flag.
REQ-015 Port: Instr  output  WIDTH  instruction register contents.
REQ-016 Port: Opcode 6, Rs 5, Rt 5, Rd 5, Shamt 5, Funct 6  outputs  decoded from Instr bits [31:26],[25:21],[20:16],[15:11],[10:6],[5:0].
REQ-017 Port: Imm  output  WIDTH/2  Instr[15:0], feeds sign-extension stage.
REQ-018 Port: JAddr  output  26  Instr[25:0].
REQ-019 Port: MDR  output  WIDTH  memory data register.

Function
REQ-020 FSM states: IDLE, FETCH, DONE; encoding free.
REQ-021 IDLE: IRWrite=1 -> latch PC into MemAddr, clear Fault, clear timeout counter, go FETCH next cycle.
REQ-022 FETCH: MemRead=1 combinationally; MemAddr holds latched value regardless of PC changes.
REQ-023 FETCH with MemReady=1 and Flush=0 -> Instr <= MemData, go DONE.
REQ-024 FETCH with MemReady=0 -> counter increments; counter reaching TIMEOUT with no MemReady -> Fault <= 1, go IDLE, Instr unchanged.
REQ-025 DONE: IRDone=1 for exactly this cycle; unconditional return to IDLE; IRWrite in DONE ignored.
REQ-026 IRWrite while in FETCH or DONE: ignored, no relatch of MemAddr.
REQ-027 Flush=1 in FETCH: go IDLE next cycle, Instr unchanged, Fault unchanged, no IRDone; Flush wins over simultaneous MemReady.
REQ-028 Flush in IDLE or DONE: no effect (DONE still pulses IRDone).
REQ-029 MDR <= MemData on every cycle MemReady=1, any state, independent of Flush.
REQ-030 Field outputs purely combinational from Instr; Instr changes only per REQ-023.
REQ-031 Busy=1 in FETCH and DONE; MemRead=0 outside FETCH.
REQ-032 Latency: IRWrite sampled at edge N, MemReady at edge N+k (k>=1) -> Instr valid after edge N+k, IRDone high during cycle after that edge.
REQ-033 Fault persists through IDLE until next accepted IRWrite or reset.

Reset
REQ-034 reset=0 asynchronously forces IDLE; Instr, MDR, MemAddr, counter = 0; Fault, IRDone, MemRead, Busy = 0.
REQ-035 Reset asserted mid-FETCH aborts immediately; no IRDone emitted; outputs reach reset values without waiting for clk.
REQ-036 After reset release, first accepted IRWrite follows REQ-021.

Verification
REQ-037 PC=0x00400000, IRWrite pulse, MemReady after 2 cycles with MemData=0x2008FFFC -> MemAddr=0x00400000, Opcode=0x08, Rs=0, Rt=8, Imm=0xFFFC, one IRDone pulse, Busy low after.
REQ-038 IRWrite, MemReady never asserted -> Fault=1 after 15 FETCH cycles, state IDLE, Instr retains prior value; next IRWrite clears Fault.
REQ-039 FETCH with Flush=1 and MemReady=1 same cycle, MemData=0x12345678 -> Instr unchanged, MDR=0x12345678, no IRDone.
REQ-040 IRWrite held high continuously with PC changing each cycle -> each fetch uses PC sampled in IDLE only; IRDone pulses separated by >=1 IDLE cycle.
REQ-041 reset driven low between clock edges during FETCH -> all outputs 0 immediately, MemRead drops before next edge.
REQ-042 MemData=0x0C100010 fetched -> Opcode=0x03, JAddr=0x0100010, Funct=0x10, Shamt=0.
